bcd_mmss_timer: RTL and testbench

//  mm:ss BCD timer/stopwatch driving the 4-digit seven-segment display stage.

---
 rtl/bcd_mmss_timer.sv | 93 +++++++++
 tb/tb_bcd_mmss_timer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_mmss_timer.sv
// bcd_mmss_timer: mm:ss BCD up/down timer with load/start/pause; defining TIMER_BLINK_EN blanks num1..num4 in PAUSE/DONE while blink=1
module bcd_mmss_timer #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       dir,
  input  logic [3:0] ld_min10,
  input  logic [3:0] ld_min1,
  input  logic [3:0] ld_sec10,
  input  logic [3:0] ld_sec1,
  input  logic       blink,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       running,
  output logic       done
);
  if (MAX_MIN < 0 || MAX_MIN > 99) begin : g_chk
    $error("MAX_MIN must be 0..99");
  end
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] MX10 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MX1 = 4'(MAX_MIN % 10);
  localparam logic [15:0] MAXV = {MX10, MX1, 4'd5, 4'd9};
  state_t st_q, st_d;
  logic dir_q, dir_d;
  logic [15:0] cnt_q, cnt_d, ld_v, up_v, dn_v, nxt_v;
  logic [3:0] m10, m1, s10, s1, c10, c1, cs10, cs1;
  logic cy1, cy2, cy3, bw1, bw2, bw3, hold, term, blank;
  assign {m10, m1, s10, s1} = cnt_q;
  always_comb begin
    c10 = ld_min10 > 4'd9 ? 4'd9 : ld_min10;
    c1 = ld_min1 > 4'd9 ? 4'd9 : ld_min1;
    cs10 = ld_sec10 > 4'd5 ? 4'd5 : ld_sec10;
    cs1 = ld_sec1 > 4'd9 ? 4'd9 : ld_sec1;
    ld_v = {c10, c1} > {MX10, MX1} ? MAXV : {c10, c1, cs10, cs1};
    cy1 = s1 == 4'd9;
    cy2 = cy1 && s10 == 4'd5;
    cy3 = cy2 && m1 == 4'd9;
    up_v = {cy3 ? m10 + 4'd1 : m10, cy2 ? (cy3 ? 4'd0 : m1 + 4'd1) : m1,
            cy1 ? (cy2 ? 4'd0 : s10 + 4'd1) : s10, cy1 ? 4'd0 : s1 + 4'd1};
    bw1 = s1 == 4'd0;
    bw2 = bw1 && s10 == 4'd0;
    bw3 = bw2 && m1 == 4'd0;
    dn_v = {bw3 ? m10 - 4'd1 : m10, bw2 ? (bw3 ? 4'd9 : m1 - 4'd1) : m1,
            bw1 ? (bw2 ? 4'd5 : s10 - 4'd1) : s10, bw1 ? 4'd9 : s1 - 4'd1};
    nxt_v = dir_q ? dn_v : up_v;
    hold = dir_q ? cnt_q == 16'h0 : cnt_q == MAXV;
    term = dir_q ? nxt_v == 16'h0 : nxt_v == MAXV;
    st_d = st_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (st_q != RUN && load) begin
      cnt_d = ld_v;
      st_d = st_q == DONE ? IDLE : st_q;
    end else if ((st_q == IDLE || st_q == DONE) && start) begin
      dir_d = dir;
      st_d = dir && cnt_q == 16'h0 ? DONE : RUN;
    end else if (st_q == RUN) begin
      cnt_d = tick && !hold ? nxt_v : cnt_q;
      st_d = tick && (hold || term) ? DONE : pause ? PAUSE : RUN;
    end else if (st_q == PAUSE && pause) begin
      st_d = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= IDLE;
      dir_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef TIMER_BLINK_EN
  assign blank = blink && (st_q == PAUSE || st_q == DONE);
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blank = 1'b0;
`endif
  assign {num1, num2, num3, num4} = blank ? 16'hFFFF : cnt_q;
  assign running = st_q == RUN;
  assign done = st_q == DONE;
endmodule

// File: tb/tb_bcd_mmss_timer.sv
// tb_bcd_mmss_timer: vector table plus multi-cycle sequences, expectations queued and checked after each edge
module tb_bcd_mmss_timer;
  logic clk = 1'b0, rst, tick, start, pause, load, dir, blink;
  logic [3:0] ld_min10, ld_min1, ld_sec10, ld_sec1, num1, num2, num3, num4;
  logic running, done;
  int errors = 0, checks = 0;
  logic [17:0] exp_q[$];
  string nm_q[$];
  typedef struct packed {
    logic r, l, s, p, t, d;
    logic [15:0] lv, en;
    logic er, ed;
  } vec_t;
  vec_t tbl[29];
  bcd_mmss_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .load(load),
    .dir(dir), .ld_min10(ld_min10), .ld_min1(ld_min1), .ld_sec10(ld_sec10),
    .ld_sec1(ld_sec1), .blink(blink), .num1(num1), .num2(num2), .num3(num3),
    .num4(num4), .running(running), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int s);
    int m = s / 60, x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction
  task automatic apply(input logic r, l, s, p, t, d, input logic [15:0] lv,
                       input logic [17:0] e, input string nm);
    logic [17:0] got, want;
    string n;
    @(negedge clk);
    {rst, load, start, pause, tick, dir} = {r, l, s, p, t, d};
    {ld_min10, ld_min1, ld_sec10, ld_sec1} = lv;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    got = {num1, num2, num3, num4, running, done};
    want = exp_q.pop_front();
    n = nm_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got num=%h run=%b done=%b, want num=%h run=%b done=%b",
               n, got[17:2], got[1], got[0], want[17:2], want[1], want[0]);
    end
  endtask
  task automatic ticks(input int n, input int s0, input bit down, input string nm);
    for (int i = 1; i <= n; i++) begin
      int s = down ? s0 - i : s0 + i;
      bit fin = down ? s == 0 : s == 3599;
      apply(1, 0, 0, 0, 1, 0, 16'h0, {to_bcd(s), !fin, fin}, $sformatf("%s[%0d]", nm, i));
    end
  endtask
  initial begin
    {rst, tick, start, pause, load, dir, blink} = '0;
    {ld_min10, ld_min1, ld_sec10, ld_sec1} = '0;
    //          r  l  s  p  t  d   load     expect   run done
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 16'h0058, 16'h0058, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, 16'h0000, 16'h0058, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0059, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0101, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0101, 1, 0};
    tbl[7]  = '{1, 1, 1, 0, 0, 1, 16'h0000, 16'h0101, 1, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0, 16'h0000, 16'h0101, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0101, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 16'h7C8F, 16'h5959, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 16'h0000, 16'h5959, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h5959, 0, 1};
    tbl[13] = '{1, 1, 0, 0, 0, 0, 16'h5958, 16'h5958, 0, 0};
    tbl[14] = '{1, 0, 1, 0, 0, 0, 16'h0000, 16'h5958, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h5959, 0, 1};
    tbl[16] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h5959, 0, 1};
    tbl[17] = '{1, 0, 1, 0, 0, 1, 16'h0000, 16'h5959, 1, 0};
    tbl[18] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h5958, 1, 0};
    tbl[19] = '{0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[20] = '{1, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1};
    tbl[21] = '{1, 1, 0, 0, 0, 0, 16'h3973, 16'h3953, 0, 0};
    tbl[22] = '{1, 1, 0, 0, 0, 0, 16'h9999, 16'h5959, 0, 0};
    tbl[23] = '{1, 1, 0, 0, 0, 0, 16'h00A0, 16'h0050, 0, 0};
    tbl[24] = '{1, 0, 1, 0, 0, 1, 16'h0000, 16'h0050, 1, 0};
    tbl[25] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0049, 1, 0};
    tbl[26] = '{1, 0, 0, 1, 1, 0, 16'h0000, 16'h0048, 0, 0};
    tbl[27] = '{1, 0, 1, 1, 0, 0, 16'h0000, 16'h0048, 1, 0};
    tbl[28] = '{1, 0, 0, 0, 1, 0, 16'h0000, 16'h0047, 1, 0};
    for (int i = 0; i < 29; i++)
      apply(tbl[i].r, tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].d, tbl[i].lv,
            {tbl[i].en, tbl[i].er, tbl[i].ed}, $sformatf("tbl[%0d]", i));
    apply(0, 0, 0, 0, 0, 0, 16'h0, {16'h0000, 2'b00}, "dn60_rst");
    apply(1, 1, 0, 0, 0, 0, 16'h0100, {16'h0100, 2'b00}, "dn60_load");
    apply(1, 0, 1, 0, 0, 1, 16'h0, {16'h0100, 2'b10}, "dn60_start");
    ticks(60, 60, 1, "dn60");
    for (int i = 0; i < 3; i++)
      apply(1, 0, 0, 0, 1, 0, 16'h0, {16'h0000, 2'b01}, $sformatf("dn60_hold%0d", i));
    apply(1, 1, 0, 0, 0, 0, 16'h0950, {16'h0950, 2'b00}, "up_carry_load");
    apply(1, 0, 1, 0, 0, 0, 16'h0, {16'h0950, 2'b10}, "up_carry_start");
    ticks(15, 590, 0, "up_carry");
    apply(0, 0, 0, 0, 0, 0, 16'h0, {16'h0000, 2'b00}, "dn_borrow_rst");
    apply(1, 1, 0, 0, 0, 0, 16'h1002, {16'h1002, 2'b00}, "dn_borrow_load");
    apply(1, 0, 1, 0, 0, 1, 16'h0, {16'h1002, 2'b10}, "dn_borrow_start");
    ticks(5, 602, 1, "dn_borrow");
    apply(0, 0, 0, 0, 0, 0, 16'h0, {16'h0000, 2'b00}, "ps_rst");
    apply(1, 1, 0, 0, 0, 0, 16'h0010, {16'h0010, 2'b00}, "ps_load");
    apply(1, 0, 1, 0, 0, 0, 16'h0, {16'h0010, 2'b10}, "ps_start");
    apply(1, 0, 0, 1, 1, 0, 16'h0, {16'h0011, 2'b00}, "ps_tick_pause");
    for (int i = 0; i < 5; i++)
      apply(1, 0, 0, 0, 1, 0, 16'h0, {16'h0011, 2'b00}, $sformatf("ps_drop%0d", i));
    apply(1, 0, 0, 1, 0, 0, 16'h0, {16'h0011, 2'b10}, "ps_resume");
    apply(1, 0, 0, 0, 1, 0, 16'h0, {16'h0012, 2'b10}, "ps_run_tick");
`ifdef TIMER_BLINK_EN
    apply(1, 0, 0, 1, 0, 0, 16'h0, {16'h0012, 2'b00}, "blk_pause");
    blink = 1'b1;
    apply(1, 0, 0, 0, 0, 0, 16'h0, {16'hFFFF, 2'b00}, "blk_on");
    blink = 1'b0;
    apply(1, 0, 0, 0, 0, 0, 16'h0, {16'h0012, 2'b00}, "blk_off");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
